uart_tx: RTL
============

# uart_tx

Serial transmitter for the 16-bit processor's memory-mapped I/O path. It accepts one data word per valid/ready handshake from the I/O write logic and shifts it out on a single line as an 8N1 asynchronous frame: start bit, data LSB first, one stop bit. It is the transmit end of the board serial link and pairs with the host-side terminal.

## Interface
- WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range ≥ 2.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  WIDTH  word to send; sampled only on the handshake edge.
- tx_valid  in  1  requester has a word on tx_data.
- tx_ready  out  1  block can accept a word; high only in IDLE.
- tx  out  1  serial line, registered, idle-high.
- busy  out  1  frame in progress; equals ~tx_ready.

## Operation
- States: IDLE, START, DATA, STOP.
  - IDLE: tx=1, tx_ready=1.
    - tx_valid=1 at an edge: tx_data is latched into the shift register, the bit counter is cleared, the baud counter is cleared, and the state moves to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift register bit 0.
    - Every CLKS_PER_BIT cycles: shift right by one and increment the bit index.
    - After bit index WIDTH-1 completes, move to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 when a bit period ends.
  - Held at 0 in IDLE.
- Bit index:
  - Width is $clog2(WIDTH)+1.
  - Changes only in DATA.
- tx_data and tx_valid are ignored outside IDLE. No queueing: a word offered while busy stays pending until tx_ready rises.
- Reset values: state=IDLE, tx=1, tx_ready=1, busy=0, both counters 0, shift register 0.
- Reset mid-frame aborts the frame. tx is 1 and tx_ready is 1 after the reset edge, and nothing is retransmitted.
- Reset and tx_valid together: reset wins and the word is not accepted.

## Timing
- Handshake at edge N (IDLE, tx_valid=1):
  - tx falls at N+1.
  - tx_ready falls at N+1.
- Start bit occupies edges N+1 .. N+CLKS_PER_BIT.
- Data bit k starts at edge N+1+(k+1)·CLKS_PER_BIT.
- Stop bit starts at edge N+1+(WIDTH+1)·CLKS_PER_BIT.
- tx_ready rises at edge N+1+(WIDTH+2)·CLKS_PER_BIT.
- Frame length is exactly (WIDTH+2)·CLKS_PER_BIT cycles.
- Back-to-back frames: a requester holding tx_valid high is accepted on the first IDLE cycle. This gives exactly one extra idle-high clock between a stop bit and the next start bit.
- tx is driven straight from a flop, with no combinational path from any input. tx_ready is decoded from the state register only.

## Structure
- Shared package uart_pkg holds:
  - the state enumeration (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the default CLKS_PER_BIT;
  - the frame-length constant (WIDTH+2).
- One sub-module: uart_baud_gen.
  - Holds the parameterised CLKS_PER_BIT counter.
  - Ports: clk, reset, clear, tick.
  - tick is high in the last cycle of each bit period.
- The FSM, shift register and bit index stay in uart_tx.

## Test plan
Bench uses CLKS_PER_BIT=4 and WIDTH=8; a frame is 40 cycles.

- **Reset:** hold reset 3 cycles, then release -> tx=1, tx_ready=1, busy=0 on every cycle; no change for 20 idle cycles with tx_valid=0.
- **Single frame:** tx_data=8'hA5, pulse tx_valid 1 cycle at edge N -> tx per bit slot reads 0,1,0,1,0,0,1,0,1,1, each slot 4 cycles, first slot starting at N+1; tx_ready returns at N+41.
- **Data stability:** accept 8'h3C, then change tx_data to 8'hFF during the frame -> line still carries 0x3C (LSB first: 0,0,1,1,1,1,0,0).
- **Back-to-back:** tx_valid held high with 8'h00, then 8'hFF -> second start bit begins exactly 1 idle-high cycle after the first stop bit ends; two complete, correct frames.
- **Reset mid-frame:** assert reset at cycle 17 of a frame (during DATA) -> tx=1 and tx_ready=1 at the next edge; a later 8'h81 frame is bit-exact.
- **Busy ignore:** pulse tx_valid with 8'h55 while busy -> no second frame; only the original word is transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and its baud generator:
//   state_t              - transmitter FSM state encoding
//   DEFAULT_WIDTH        - data bits per frame
//   DEFAULT_CLKS_PER_BIT - clocks per serial bit (50 MHz / 115200 baud)
//   FRAME_BITS           - bit slots per 8N1 frame (start + data + stop)
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH        = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   // One start bit, DEFAULT_WIDTH data bits, one stop bit.
   localparam int FRAME_BITS = DEFAULT_WIDTH + 2;

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps; tick marks the last clock of every bit period.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   clear - holds the counter at 0 (used while the transmitter is idle)
//   tick  - high during the final cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   // tick depends only on the counter register; clear never gates it, so
   // it adds no combinational path from the transmitter's inputs.
   assign tick = (count == LAST);

   // NOTE: sequential state is always written with <= so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter: accepts one word per valid/ready handshake and
// sends start bit, data LSB first, then one stop bit.
// Ports:
//   clk      - system clock, all state changes on its rising edge
//   reset    - synchronous, active-high reset; aborts any frame in flight
//   tx_data  - word to send, sampled only on the handshake edge
//   tx_valid - requester has a word on tx_data
//   tx_ready - block can accept a word (high only in IDLE)
//   tx       - registered serial line, idle-high
//   busy     - frame in progress, always ~tx_ready
// ---------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int WIDTH        = DEFAULT_WIDTH,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx,
   output logic             busy
);

   // One extra bit so the index can step past the last data bit.
   localparam int BIT_W = $clog2(WIDTH) + 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic [BIT_W-1:0] bit_idx;
   logic             tick;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk  (clk),
      .reset(reset),
      .clear(state == IDLE),
      .tick (tick)
   );

   assign shift_next = shift_reg >> 1;

   // Handshake outputs are pure decodes of the state register.
   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // tx is loaded with the value for the coming bit slot on the same edge
   // that changes state, so the line is a flop output and moves in step
   // with the FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         // NOTE: the shift register is a single word of datapath, not a
         // memory array, so it is cleared on reset to keep it free of X.
         shift_reg <= '0;
         bit_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (tx_valid) begin
                  shift_reg <= tx_data;
                  bit_idx   <= '0;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end

            START: begin
               if (tick) begin
                  tx    <= shift_reg[0];
                  state <= DATA;
               end
            end

            DATA: begin
               if (tick) begin
                  shift_reg <= shift_next;
                  bit_idx   <= bit_idx + BIT_W'(1);
                  if (bit_idx == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx <= shift_next[0];
                  end
               end
            end

            STOP: begin
               tx <= 1'b1;
               if (tick) begin
                  state <= IDLE;
               end
            end

            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
